// File: rtl/multi_xfer_seq.sv
// Decode-stage micro-sequencer for LM/SM/LA/SA: issues one register transfer per
// non-stalled cycle and flags the last transfer so the controller can release PC.
module multi_xfer_seq #(
   parameter int NREG  = 8,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      IM_d,
   input  logic             id_valid,
   input  logic             stall,
   input  logic             flush,
   output logic [IDX_W-1:0] regr,
   output logic             comp,
   output logic             comp1,
   output logic [IDX_W-1:0] offset,
   output logic             busy
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREG - 1);

   state_t            state_q, state_d;
   logic [NREG-1:0]   rem_q, rem_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              mode_a_q, mode_a_d;

   logic              is_m, is_a;
   logic [NREG-1:0]   mask;
   logic              unused_im;

   // Bits 11:8 carry Ra, which the address path consumes, not this block.
   assign unused_im = ^IM_d[11:8];

   function automatic logic [IDX_W-1:0] low_idx(input logic [NREG-1:0] m);
      low_idx = '0;
      for (int k = NREG - 1; k >= 0; k--) begin
         if (m[k]) low_idx = k[IDX_W-1:0];
      end
   endfunction

   function automatic logic at_most_one(input logic [NREG-1:0] m);
      at_most_one = ((m & (m - NREG'(1))) == '0);
   endfunction

   // Instruction bit 7 names R0, so the mask is bit-reversed into register order.
   function automatic logic [NREG-1:0] rev_mask(input logic [NREG-1:0] m);
      for (int k = 0; k < NREG; k++) begin
         rev_mask[k] = m[NREG-1-k];
      end
   endfunction

   assign is_m = id_valid & (IM_d[15:13] == 3'b110);
   assign is_a = id_valid & (IM_d[15:13] == 3'b111);
   assign mask = rev_mask(IM_d[NREG-1:0]);

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      mode_a_d = mode_a_q;
      regr     = '0;
      offset   = '0;
      comp     = 1'b1;
      comp1    = 1'b1;
      busy     = 1'b0;

      case (state_q)
         IDLE: begin
            if (is_m) begin
               regr  = low_idx(mask);
               comp  = at_most_one(mask);
               comp1 = 1'b0;
               busy  = ~comp;
               if (!comp && !stall && !flush) begin
                  state_d  = RUN;
                  rem_d    = mask & (mask - NREG'(1));
                  cnt_d    = IDX_W'(1);
                  mode_a_d = 1'b0;
               end
            end else if (is_a) begin
               comp  = 1'b0;
               comp1 = 1'b0;
               busy  = 1'b1;
               if (!stall && !flush) begin
                  state_d  = RUN;
                  rem_d    = '0;
                  cnt_d    = IDX_W'(1);
                  mode_a_d = 1'b1;
               end
            end
         end

         RUN: begin
            offset = cnt_q;
            if (mode_a_q) begin
               regr  = cnt_q;
               comp  = 1'b0;
               comp1 = (cnt_q == LAST_IDX);
               busy  = ~comp1;
            end else begin
               regr  = low_idx(rem_q);
               comp  = at_most_one(rem_q);
               comp1 = 1'b0;
               busy  = ~comp;
            end

            // Flush wins over advance; the final transfer also drops back to IDLE.
            if (flush || (!stall && (comp & comp1) == 1'b0 && (mode_a_q ? comp1 : comp))) begin
               state_d = IDLE;
               rem_d   = '0;
               cnt_d   = '0;
            end else if (!stall) begin
               rem_d = rem_q & (rem_q - NREG'(1));
               cnt_d = cnt_q + IDX_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rem_q    <= '0;
         cnt_q    <= '0;
         mode_a_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         mode_a_q <= mode_a_d;
      end
   end

endmodule

// File: tb/tb_multi_xfer_seq.sv
// Scoreboard bench for multi_xfer_seq: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_multi_xfer_seq;

   logic        clk;
   logic        rst_n;
   logic [15:0] IM_d;
   logic        id_valid;
   logic        stall;
   logic        flush;
   logic [2:0]  regr;
   logic        comp;
   logic        comp1;
   logic [2:0]  offset;
   logic        busy;

   typedef struct {
      string      name;
      logic [2:0] regr;
      logic [2:0] offset;
      logic       comp;
      logic       comp1;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   multi_xfer_seq #(.NREG(8), .IDX_W(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .IM_d     (IM_d),
      .id_valid (id_valid),
      .stall    (stall),
      .flush    (flush),
      .regr     (regr),
      .comp     (comp),
      .comp1    (comp1),
      .offset   (offset),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one expected record per cycle, sampled mid-cycle on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({regr, offset, comp, comp1, busy} !== {e.regr, e.offset, e.comp, e.comp1, e.busy}) begin
               n_errors++;
               $display("FAIL %s: got regr=%0d off=%0d comp=%b comp1=%b busy=%b, want regr=%0d off=%0d comp=%b comp1=%b busy=%b",
                        e.name, regr, offset, comp, comp1, busy,
                        e.regr, e.offset, e.comp, e.comp1, e.busy);
            end
         end
      end
   end

   task automatic push_exp(input string nm, input int r, input int o,
                           input logic c, input logic c1, input logic b);
      exp_t e;
      e.name   = nm;
      e.regr   = 3'(r);
      e.offset = 3'(o);
      e.comp   = c;
      e.comp1  = c1;
      e.busy   = b;
      exp_q.push_back(e);
   endtask

   // Drive one cycle's inputs just after the rising edge and queue its expectation.
   task automatic step(input string nm, input logic [15:0] im, input logic v,
                       input logic st, input logic fl, input int r, input int o,
                       input logic c, input logic c1, input logic b);
      IM_d     = im;
      id_valid = v;
      stall    = st;
      flush    = fl;
      push_exp(nm, r, o, c, c1, b);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      IM_d     = 16'h0000;
      id_valid = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
      @(posedge clk);
      #1;

      // Reset: idle outputs for a bubble.
      step("reset_idle", 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      rst_n = 1'b1;
      step("bubble_idle", 16'hC0FF, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);

      // LM R0,R2,R7.
      step("lm_a_0", 16'hC0A1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
      step("lm_a_1", 16'hC0A1, 1'b1, 1'b0, 1'b0, 2, 1, 1'b0, 1'b0, 1'b1);
      step("lm_a_2", 16'hC0A1, 1'b1, 1'b0, 1'b0, 7, 2, 1'b1, 1'b0, 1'b0);

      // SM with empty mask directly after: single cycle, no RUN.
      step("sm_zero", 16'hD000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
      step("add_after_sm", 16'h0123, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);

      // SA: eight transfers, comp1 only on the last.
      for (int k = 0; k < 8; k++) begin
         step($sformatf("sa_%0d", k), 16'hF000, 1'b1, 1'b0, 1'b0, k, k,
              1'b0, (k == 7), (k != 7));
      end

      // LM 0xFF with a two-cycle stall while showing R3.
      for (int k = 0; k < 3; k++)
         step($sformatf("lmff_%0d", k), 16'hC0FF, 1'b1, 1'b0, 1'b0, k, k, 1'b0, 1'b0, 1'b1);
      step("lmff_stall0", 16'hC0FF, 1'b1, 1'b1, 1'b0, 3, 3, 1'b0, 1'b0, 1'b1);
      step("lmff_stall1", 16'hC0FF, 1'b1, 1'b1, 1'b0, 3, 3, 1'b0, 1'b0, 1'b1);
      step("lmff_3", 16'hC0FF, 1'b1, 1'b0, 1'b0, 3, 3, 1'b0, 1'b0, 1'b1);
      for (int k = 4; k < 8; k++)
         step($sformatf("lmff_%0d", k), 16'hC0FF, 1'b1, 1'b0, 1'b0, k, k,
              (k == 7), 1'b0, (k != 7));

      // LA flushed while showing R4; the following ADD must see idle flags.
      for (int k = 0; k < 4; k++)
         step($sformatf("la_%0d", k), 16'hE000, 1'b1, 1'b0, 1'b0, k, k, 1'b0, 1'b0, 1'b1);
      step("la_flush", 16'hE000, 1'b1, 1'b0, 1'b1, 4, 4, 1'b0, 1'b0, 1'b1);
      step("add_after_flush", 16'h0000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);

      // LM R0,R1,R2 with a short reset pulse inside the cycle that would show R2.
      step("lme0_0", 16'hC0E0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
      step("lme0_1", 16'hC0E0, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, 1'b1);
      IM_d = 16'hC0E0;
      push_exp("lme0_async_rst", 0, 0, 1'b0, 1'b0, 1'b1);
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      step("lme0_restart_1", 16'hC0E0, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, 1'b1);
      step("lme0_restart_2", 16'hC0E0, 1'b1, 1'b0, 1'b0, 2, 2, 1'b1, 1'b0, 1'b0);
      step("idle_end", 16'h0000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);

      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multi_xfer_seq.md
Name: multi_xfer_seq

Overview:
- Micro-sequencer for the multi-register instructions LM (1100), SM (1101), LA (1110) and SA (1111) in the decode stage of the 6-stage pipeline.
- It drives the three signals the decode controller consumes:
  - `regr`: the register index for the current transfer.
  - `comp`: last-transfer flag for LM/SM.
  - `comp1`: last-transfer flag for LA/SA.
- It also supplies the memory word offset and a busy flag that holds the decode register.
- The decode controller stalls PC with `pcwrite = comp`/`comp1`. This block produces exactly one transfer per non-stalled cycle until the instruction completes.

Parameters:
- NREG, 8, number of architectural registers; must equal the LM/SM mask width.
- IDX_W, 3, register index / offset width, log2(NREG).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- IM_d  input  16  instruction currently in the decode register.
- id_valid  input  1  `IM_d` holds a real (non-bubble) instruction.
- stall  input  1  pipeline hold from hazard unit; freezes sequence state.
- flush  input  1  decode-stage flush (taken branch/jump); aborts the sequence.
- regr  output  3  register index of the current transfer.
- comp  output  1  high on the final LM/SM transfer cycle.
- comp1  output  1  high on the final LA/SA transfer cycle.
- offset  output  3  word offset from the base (Ra) for the current transfer.
- busy  output  1  sequence in progress and not on its final cycle; decode register must hold.

Behaviour:
- Decode:
  - `is_m` = `id_valid` & (`IM_d[15:12]` == 1100 or 1101).
  - `is_a` = `id_valid` & (`IM_d[15:12]` == 1110 or 1111).
  - Otherwise: `regr` = 0, `offset` = 0, `comp` = 1, `comp1` = 1, `busy` = 0. Completion flags are high so `pcwrite` is never blocked by this block for non-multi instructions.
- Mask mapping (LM/SM): `IM_d[7-k]` selects Rk (bit 7 = R0, bit 0 = R7). Transfers occur in ascending register order.
- States:
  - IDLE: no sequence in progress.
  - RUN: holds `rem[7:0]`, the remaining unserviced mask in register order, and `cnt[2:0]`, the transfers already done.
- IDLE with `is_m`:
  - Effective mask = reversed `IM_d[7:0]`.
  - `regr` = lowest set index. `offset` = 0. Outputs are combinational from `IM_d` this cycle.
  - `comp` = 1 if exactly one or zero bits are set.
  - Zero mask: single cycle, `regr` = 0, `comp` = 1. The controller suppresses the write for this case.
  - If not final and not stalled: go to RUN with `rem` = mask with the lowest bit cleared and `cnt` = 1.
- RUN (LM/SM):
  - `regr` = lowest set bit of `rem`. `offset` = `cnt`.
  - `comp` = 1 when `rem` has exactly one bit set.
  - Non-stalled cycle: clear that bit and increment `cnt`.
  - On `comp` & !`stall`: return to IDLE.
- IDLE with `is_a`:
  - `regr` = 0, `offset` = 0, `comp1` = 0.
  - Go to RUN with `cnt` = 1.
- RUN (LA/SA):
  - `regr` = `cnt`, `offset` = `cnt`.
  - `comp1` = 1 when `cnt` == 7.
  - The next non-stalled cycle after that returns to IDLE. Total of exactly 8 cycles.
- Unused flag during a sequence: `comp1` = 0 throughout LM/SM; `comp` = 0 throughout LA/SA.
- `busy` = `is_m`/`is_a` & !final-flag, whether in IDLE or RUN.
- `stall`: state (`rem`, `cnt`, state) is held. Outputs keep showing the same transfer. `comp`/`comp1` stay at their held value.
- `flush`: forces IDLE next edge and has priority over advance. Outputs in the flush cycle follow the normal rules.
- Back-to-back multi instructions: the IDLE return on the final cycle lets the next instruction start on the following cycle with no bubble.
- `cnt` width: 3 bits. It never wraps within a sequence; the maximum transfer count is 8 (`offset` 0..7).
- Reset: state = IDLE, `rem` = 0, `cnt` = 0. Outputs then follow the IDLE rules for the current `IM_d`. With `id_valid` = 0: `regr` = 0, `offset` = 0, `comp` = 1, `comp1` = 1, `busy` = 0.
  - Reset asserted mid-sequence aborts immediately and asynchronously.

Test Plan:
- LM with `IM_d` = 1100_000_0_1010_0001 (R0, R2, R7):
  - `regr` 0, 2, 7 on three consecutive cycles; `offset` 0, 1, 2.
  - `comp` = 0, 0, 1; `busy` = 1, 1, 0; `comp1` = 0 throughout.
- SM with mask 0x00 -> one cycle, `regr` = 0, `comp` = 1, `busy` = 0, no RUN entry.
- SA -> 8 cycles, `regr` = `offset` = 0..7, `comp1` high only on cycle 8, `comp` = 0 throughout.
- LM mask 0xFF with `stall` high for 2 cycles at `regr` = 3 -> `regr` holds at 3 for 3 cycles, then continues 4..7; total 10 cycles.
- LA `flush` asserted at `regr` = 4 -> next cycle IDLE. A following ADD shows `comp` = `comp1` = 1, `busy` = 0.
- `rst_n` pulsed low at `regr` = 2 of LM mask 0xE0 -> asynchronous return to IDLE; after release the sequence restarts at `regr` = 0, `offset` = 0.
